// File: rtl/rsm_pkg.sv
// Shared types and constants for the Simple RISC Machine fetch, decode and control blocks.
package rsm_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 9;

    localparam logic [2:0] OPC_HALT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_pc_next.sv
// Next-PC selection: sequential pc+1 (wrapping) or a datapath-supplied redirect target.
module pc_next #(
    parameter int ADDR_W = 9
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic [ADDR_W-1:0] o_pc_plus1,
    output logic [ADDR_W-1:0] o_pc_next
);

    logic [ADDR_W-1:0] w_pc_plus1;

    // Plain modular add: 1FF + 1 wraps to 000 with no carry out.
    assign w_pc_plus1 = i_pc + ADDR_W'(1);
    assign o_pc_plus1 = w_pc_plus1;
    assign o_pc_next  = i_redirect_valid ? i_redirect_pc : w_pc_plus1;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, reads instruction words over ready/valid, holds the IR
// for the controller and applies its next-PC decision when the instruction retires.
module instruction_fetch
    import rsm_pkg::*;
#(
    parameter int                   ADDR_W   = rsm_pkg::ADDR_W,
    parameter int                   DATA_W   = rsm_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ack,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              halted
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic              r_mem_rd;
    logic              r_ir_valid;
    logic              r_halted;
    logic              w_mem_rd_next;
    logic              w_ir_valid_next;
    logic              w_halted_next;
    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_capture;
    logic              w_retire;
    logic              w_halt_op;

    assign w_capture = (r_state == FETCH) && mem_ready;
    assign w_retire  = (r_state == VALID) && ir_ack;
    assign w_halt_op = (r_ir[DATA_W-1 -: 3] == OPC_HALT);

    pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .i_pc             (r_pc),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_pc_plus1       (w_pc_plus1),
        .o_pc_next        (w_pc_next)
    );

    // State register; the status outputs are registered alongside it so they never glitch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_mem_rd   <= 1'b0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_mem_rd   <= w_mem_rd_next;
            r_ir_valid <= w_ir_valid_next;
            r_halted   <= w_halted_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    w_state_next = FETCH;
            FETCH:   if (mem_ready) w_state_next = VALID;
            VALID:   if (ir_ack) w_state_next = w_halt_op ? HALT : FETCH;
            HALT:    w_state_next = HALT;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_mem_rd_next   = (w_state_next == FETCH);
        w_ir_valid_next = (w_state_next == VALID);
        w_halted_next   = (w_state_next == HALT);
    end

    // A retiring HALT keeps its own address in pc, whatever redirect says.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
            r_ir <= '0;
        end else begin
            if (w_capture) begin
                r_ir <= mem_rdata;
            end
            if (w_retire && !w_halt_op) begin
                r_pc <= w_pc_next;
            end
        end
    end

    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_pc;
    assign ir       = r_ir;
    assign ir_valid = r_ir_valid;
    assign pc       = r_pc;
    assign pc_plus1 = w_pc_plus1;
    assign halted   = r_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: a program-level model tracks the expected
// pc and ir, and each scenario task checks the handshake against it cycle by cycle.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_rd;
    logic [8:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ack;
    logic        redirect_valid;
    logic [8:0]  redirect_pc;
    logic [8:0]  pc;
    logic [8:0]  pc_plus1;
    logic        halted;

    int tests = 0;
    int fails = 0;

    // Model: pc of the instruction being fetched/held, last captured word, halt flag.
    logic [8:0]  m_pc;
    logic [15:0] m_ir;
    bit          m_halted;

    instruction_fetch #(
        .ADDR_W   (9),
        .DATA_W   (16),
        .RESET_PC (9'h000)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .ir             (ir),
        .ir_valid       (ir_valid),
        .ir_ack         (ir_ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .pc_plus1       (pc_plus1),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Precondition: current cycle is FETCH at m_pc. Inserts 'waits' stall cycles with
    // noise on the ignored inputs, then returns the word; ends in the first VALID cycle.
    task automatic do_fetch(input logic [15:0] word, input int waits, input string tag);
        for (int w = 0; w <= waits; w++) begin
            tests++; if (mem_rd !== 1'b1) begin fails++; $display("FAIL %s fetch_rd w%0d: got %b want 1", tag, w, mem_rd); end
            tests++; if (mem_addr !== m_pc) begin fails++; $display("FAIL %s fetch_addr w%0d: got %h want %h", tag, w, mem_addr, m_pc); end
            tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL %s fetch_irv w%0d: got %b want 0", tag, w, ir_valid); end
            tests++; if (ir !== m_ir) begin fails++; $display("FAIL %s fetch_ir_hold w%0d: got %h want %h", tag, w, ir, m_ir); end
            if (w < waits) begin
                mem_ready      = 1'b0;
                mem_rdata      = 16'($urandom);
                ir_ack         = 1'($urandom_range(0, 1));
                redirect_valid = 1'($urandom_range(0, 1));
                redirect_pc    = 9'($urandom);
            end else begin
                mem_ready      = 1'b1;
                mem_rdata      = word;
                ir_ack         = 1'b0;
                redirect_valid = 1'b0;
            end
            tick();
        end
        mem_ready = 1'b0;
        ir_ack    = 1'b0;
        redirect_valid = 1'b0;
        m_ir = word;
        tests++; if (ir_valid !== 1'b1) begin fails++; $display("FAIL %s valid_irv: got %b want 1", tag, ir_valid); end
        tests++; if (ir !== m_ir) begin fails++; $display("FAIL %s valid_ir: got %h want %h", tag, ir, m_ir); end
        tests++; if (pc !== m_pc) begin fails++; $display("FAIL %s valid_pc: got %h want %h", tag, pc, m_pc); end
        tests++; if (pc_plus1 !== 9'((m_pc + 1) % 512)) begin fails++; $display("FAIL %s valid_pc_plus1: got %h want %h", tag, pc_plus1, 9'((m_pc + 1) % 512)); end
        tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL %s valid_rd: got %b want 0", tag, mem_rd); end
    endtask

    // Precondition: current cycle is VALID. Holds 'hold' cycles, then acks.
    task automatic do_retire(input int hold, input bit redir, input logic [8:0] rpc, input string tag);
        for (int h = 0; h < hold; h++) begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
            tick();
            tests++; if (ir_valid !== 1'b1) begin fails++; $display("FAIL %s hold_irv h%0d: got %b want 1", tag, h, ir_valid); end
            tests++; if (ir !== m_ir) begin fails++; $display("FAIL %s hold_ir h%0d: got %h want %h", tag, h, ir, m_ir); end
        end
        mem_ready      = 1'b0;
        ir_ack         = 1'b1;
        redirect_valid = redir;
        redirect_pc    = rpc;
        tick();
        ir_ack         = 1'b0;
        redirect_valid = 1'b0;
        if (m_ir[15:13] == 3'b111) m_halted = 1'b1;
        else m_pc = redir ? rpc : 9'((m_pc + 1) % 512);
        tests++; if (halted !== m_halted) begin fails++; $display("FAIL %s ret_halted: got %b want %b", tag, halted, m_halted); end
        tests++; if (mem_rd !== !m_halted) begin fails++; $display("FAIL %s ret_rd: got %b want %b", tag, mem_rd, !m_halted); end
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL %s ret_irv: got %b want 0", tag, ir_valid); end
        tests++; if (pc !== m_pc) begin fails++; $display("FAIL %s ret_pc: got %h want %h", tag, pc, m_pc); end
        tests++; if (mem_addr !== m_pc) begin fails++; $display("FAIL %s ret_addr: got %h want %h", tag, mem_addr, m_pc); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL reset mem_rd: got %b want 0", mem_rd); end
        tests++; if (ir !== 16'h0000) begin fails++; $display("FAIL reset ir: got %h want 0000", ir); end
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL reset ir_valid: got %b want 0", ir_valid); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset halted: got %b want 0", halted); end
        tests++; if (pc !== 9'h000) begin fails++; $display("FAIL reset pc: got %h want 000", pc); end
        tests++; if (mem_addr !== 9'h000) begin fails++; $display("FAIL reset mem_addr: got %h want 000", mem_addr); end
        tests++; if (pc_plus1 !== 9'h001) begin fails++; $display("FAIL reset pc_plus1: got %h want 001", pc_plus1); end
        reset_n  = 1'b1;
        m_pc     = 9'h000;
        m_ir     = 16'h0000;
        m_halted = 1'b0;
        $display("[TB] reset: pc=%h ir=%h", pc, ir);
    endtask

    task automatic test_first_fetch();
        tick();
        do_fetch(16'hD105, 0, "first");
        $display("[TB] first fetch: addr=%h ir=%h", m_pc, ir);
    endtask

    task automatic test_sequential_redirect();
        do_retire(0, 1'b1, 9'h005, "to5");
        do_fetch(16'h1234, 0, "at5");
        do_retire(1, 1'b0, 9'h0AA, "seq6");
        $display("[TB] sequential: next addr=%h", mem_addr);
        do_fetch(16'h4321, 0, "at6");
        do_retire(0, 1'b1, 9'h020, "redir20");
        $display("[TB] redirect: next addr=%h", mem_addr);
    endtask

    task automatic test_stall();
        do_fetch(16'h0F0F, 3, "stall3");
        $display("[TB] stall: addr=%h ir=%h after 3 waits", m_pc, ir);
    endtask

    task automatic test_wrap();
        do_retire(0, 1'b1, 9'h1FF, "to1ff");
        do_fetch(16'h2222, 0, "at1ff");
        do_retire(0, 1'b0, 9'h000, "wrap");
        $display("[TB] wrap: pc=%h mem_addr=%h", pc, mem_addr);
    endtask

    task automatic test_random();
        logic [15:0] word;
        logic [8:0]  rpc;
        int          waits;
        int          hold;
        bit          redir;
        for (int t = 0; t < 40; t++) begin
            word  = 16'($urandom);
            if (word[15:13] == 3'b111) word[15] = 1'b0;
            waits = $urandom_range(0, 3);
            hold  = $urandom_range(0, 2);
            redir = ($urandom_range(0, 3) == 0);
            rpc   = 9'($urandom);
            do_fetch(word, waits, "rand");
            do_retire(hold, redir, rpc, "rand");
            $display("[TB] txn %0d: ir=%h waits=%0d hold=%0d redir=%0d next=%h", t, word, waits, hold, redir, m_pc);
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_fetch(16'h5555, 0, "pre7");
        do_retire(0, 1'b1, 9'h007, "to7");
        mem_ready = 1'b0;
        tick();
        tests++; if (mem_rd !== 1'b1 || mem_addr !== 9'h007) begin fails++; $display("FAIL rst_mid stalled: got rd=%b addr=%h want rd=1 addr=007", mem_rd, mem_addr); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL rst_mid mem_rd: got %b want 0", mem_rd); end
        tests++; if (pc !== 9'h000) begin fails++; $display("FAIL rst_mid pc: got %h want 000", pc); end
        tests++; if (ir !== 16'h0000) begin fails++; $display("FAIL rst_mid ir: got %h want 0000", ir); end
        tests++; if (ir_valid !== 1'b0 || halted !== 1'b0) begin fails++; $display("FAIL rst_mid idle: got irv=%b halted=%b want 0 0", ir_valid, halted); end
        m_pc = 9'h000;
        m_ir = 16'h0000;
        tick();
        tests++; if (mem_rd !== 1'b1 || mem_addr !== 9'h000) begin fails++; $display("FAIL rst_mid refetch: got rd=%b addr=%h want rd=1 addr=000", mem_rd, mem_addr); end
        $display("[TB] reset mid-fetch: refetch addr=%h", mem_addr);
    endtask

    task automatic test_halt();
        do_fetch(16'h3000, 1, "prehalt");
        do_retire(0, 1'b0, 9'h000, "prehalt");
        do_fetch(16'hE000, 1, "halt");
        do_retire(1, 1'b1, 9'h055, "halt");
        for (int c = 0; c < 6; c++) begin
            ir_ack         = 1'($urandom_range(0, 1));
            redirect_valid = 1'($urandom_range(0, 1));
            redirect_pc    = 9'($urandom);
            mem_ready      = 1'($urandom_range(0, 1));
            mem_rdata      = 16'($urandom);
            tick();
            tests++; if (halted !== 1'b1 || mem_rd !== 1'b0 || ir_valid !== 1'b0) begin fails++; $display("FAIL halt_stay c%0d: got halted=%b rd=%b irv=%b want 1 0 0", c, halted, mem_rd, ir_valid); end
            tests++; if (pc !== m_pc || ir !== 16'hE000) begin fails++; $display("FAIL halt_hold c%0d: got pc=%h ir=%h want pc=%h ir=E000", c, pc, ir, m_pc); end
        end
        ir_ack = 1'b0;
        redirect_valid = 1'b0;
        $display("[TB] halt: pc=%h halted=%b", pc, halted);
    endtask

    initial begin
        reset_n        = 1'b0;
        mem_rdata      = 16'h0000;
        mem_ready      = 1'b0;
        ir_ack         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 9'h000;
        m_pc           = 9'h000;
        m_ir           = 16'h0000;
        m_halted       = 1'b0;
        test_reset();
        test_first_fetch();
        test_sequential_redirect();
        test_stall();
        test_wrap();
        test_random();
        test_reset_mid_fetch();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
